serial_comp_ctrl: RTL

SERIAL_COMP_CTRL -- requirements
Module: serial_comp_ctrl

---
 rtl/serial_comp_ctrl.sv | 94 +++++++++
 1 files changed

// File: rtl/serial_comp_ctrl.sv
// Bit-serial complementer: accepts a word, streams its complement LSB first, then reports dout.
// Define SERIAL_COMP_TWOS_EN for two's complement; ones' complement otherwise.
module serial_comp_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    output logic             busy,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             done,
    output logic [WIDTH-1:0] dout
);

    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {st_idle, st_shift, st_done} state_t;

    state_t           state;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] res;
    logic [CW-1:0]    cnt;
    logic             ser_bit;

`ifdef SERIAL_COMP_TWOS_EN
    logic seen;

    // Bits pass through unchanged up to and including the first 1, inverted afterwards.
    assign ser_bit = seen ? ~opnd[0] : opnd[0];
`else
    assign ser_bit = ~opnd[0];
`endif

    assign ser_valid = (state == st_shift);
    assign ser_out   = ser_valid & ser_bit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= st_idle;
            opnd  <= '0;
            res   <= '0;
            cnt   <= '0;
            dout  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
`ifdef SERIAL_COMP_TWOS_EN
            seen  <= 1'b0;
`endif
        end else begin
            unique case (state)
                st_idle: begin
                    if (start) begin
                        opnd  <= din;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= st_shift;
`ifdef SERIAL_COMP_TWOS_EN
                        seen  <= 1'b0;
`endif
                    end
                end
                st_shift: begin
                    opnd <= opnd >> 1;
                    res  <= {ser_bit, res[WIDTH-1:1]};
`ifdef SERIAL_COMP_TWOS_EN
                    seen <= seen | opnd[0];
`endif
                    // Counter parks at LAST instead of wrapping; the next start reloads it.
                    if (cnt == LAST) begin
                        dout  <= {ser_bit, res[WIDTH-1:1]};
                        done  <= 1'b1;
                        state <= st_done;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                st_done: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= st_idle;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= st_idle;
                end
            endcase
        end
    end

endmodule
